// File: rtl/usb_phy_tx.sv
// Full-speed USB device transmitter: SYNC, bit-stuffed NRZI payload and EOP onto registered dp/dn/oe.
// Latency: the first SYNC bit is on the line at the edge that accepts the first byte; a packet occupies CLK_PER_BIT clocks per bit.
// Backpressure: tx_ready is high in IDLE and for one clock at each byte boundary; a missing byte there truncates the packet with tx_err.
module usb_phy_tx #(
    parameter int CLK_PER_BIT  = 4,   // core clocks per USB bit time, >= 2
    parameter int STUFF_LEN    = 6,   // run of 1s that forces a stuffed 0, >= 2
    parameter int EOP_SE0_BITS = 2    // SE0 bit times in EOP, >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_err,
    output logic       tx_oe,
    output logic       dp_tx,
    output logic       dn_tx
);

    localparam int PW = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int BW = (EOP_SE0_BITS > 8) ? $clog2(EOP_SE0_BITS) : 3;

    localparam logic [PW-1:0] PHASE_MAX = PW'(CLK_PER_BIT - 1);
    localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LEN);
    localparam logic [BW-1:0] BIT_LAST  = BW'(7);
    localparam logic [BW-1:0] SYNC_ONE  = BW'(6);
    localparam logic [BW-1:0] SE0_LAST  = BW'(EOP_SE0_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        STUFF   = 3'd3,
        EOP_SE0 = 3'd4,
        EOP_J   = 3'd5
    } state_t;

    state_t        state, state_d;
    logic [PW-1:0] phase, phase_d;
    logic [BW-1:0] bit_cnt, bit_cnt_d;   // bit index in SYNC/byte, SE0 bit count in EOP
    logic [7:0]    shreg, shreg_d;       // current byte, bit 0 is the bit on the line
    logic          last_q, last_d;       // current byte closes the packet
    logic [OW-1:0] ones, ones_d;         // run of 1s including the bit on the line
    logic          lvl, lvl_d;           // NRZI line level, 1 = J
    logic          dp_d, dn_d, oe_d, busy_d, err_d;
    logic          idle_rdy;             // holds tx_ready low until the first clock after reset

    logic wrap, byte_end, stuff_due, fetch;
    logic adv, emit, emit_bit, to_eop;

    assign wrap      = (phase == PHASE_MAX);
    assign byte_end  = (bit_cnt == BIT_LAST);
    assign stuff_due = (ones == ONES_MAX);
    // A byte is requested only when bit 7 (or the stuff bit after it) ends and more bytes follow.
    assign fetch     = wrap && byte_end && !last_q &&
                       (((state == DATA) && !stuff_due) || (state == STUFF));

    // State register and registered line outputs; reset drives the bus back to idle J immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            last_q   <= 1'b0;
            ones     <= '0;
            lvl      <= 1'b1;
            dp_tx    <= 1'b1;
            dn_tx    <= 1'b0;
            tx_oe    <= 1'b0;
            tx_busy  <= 1'b0;
            tx_err   <= 1'b0;
            idle_rdy <= 1'b0;
        end else begin
            state    <= state_d;
            phase    <= phase_d;
            bit_cnt  <= bit_cnt_d;
            shreg    <= shreg_d;
            last_q   <= last_d;
            ones     <= ones_d;
            lvl      <= lvl_d;
            dp_tx    <= dp_d;
            dn_tx    <= dn_d;
            tx_oe    <= oe_d;
            tx_busy  <= busy_d;
            tx_err   <= err_d;
            idle_rdy <= 1'b1;
        end
    end

    // Next-state, bit sequencing, stuffing and NRZI; tx_ready decodes registered state only.
    always_comb begin
        state_d   = state;
        phase_d   = (state == IDLE || wrap) ? '0 : phase + PW'(1);
        bit_cnt_d = bit_cnt;
        shreg_d   = shreg;
        last_d    = last_q;
        ones_d    = ones;
        lvl_d     = lvl;
        dp_d      = dp_tx;
        dn_d      = dn_tx;
        oe_d      = tx_oe;
        busy_d    = tx_busy;
        err_d     = 1'b0;
        adv       = 1'b0;
        emit      = 1'b0;
        emit_bit  = 1'b0;
        to_eop    = 1'b0;
        tx_ready  = ((state == IDLE) && idle_rdy) || fetch;

        case (state)
            IDLE: begin
                if (idle_rdy && tx_valid) begin
                    state_d   = SYNC;
                    shreg_d   = tx_data;
                    last_d    = tx_last;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    busy_d    = 1'b1;
                    emit      = 1'b1;   // first SYNC bit is a 0: J -> K
                end
            end
            SYNC: begin
                if (wrap) begin
                    if (!byte_end) begin
                        bit_cnt_d = bit_cnt + BW'(1);
                        emit      = 1'b1;
                        emit_bit  = (bit_cnt == SYNC_ONE);
                    end else begin
                        // SYNC leaves the ones counter at 1, so no stuff can fall here.
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        emit      = 1'b1;
                        emit_bit  = shreg[0];
                    end
                end
            end
            DATA: begin
                if (wrap) begin
                    if (stuff_due) begin
                        state_d = STUFF;
                        emit    = 1'b1;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            STUFF: begin
                if (wrap) begin
                    adv = 1'b1;
                end
            end
            EOP_SE0: begin
                if (wrap) begin
                    if (bit_cnt == SE0_LAST) begin
                        state_d = EOP_J;
                        dp_d    = 1'b1;
                        dn_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            EOP_J: begin
                if (wrap) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    lvl_d   = 1'b1;
                    dp_d    = 1'b1;
                    dn_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Move to the next payload bit; the stuff state keeps bit_cnt/shreg so it resumes in place.
        if (adv) begin
            state_d = DATA;
            if (!byte_end) begin
                bit_cnt_d = bit_cnt + BW'(1);
                shreg_d   = shreg >> 1;
                emit      = 1'b1;
                emit_bit  = shreg[1];
            end else if (last_q) begin
                to_eop = 1'b1;
            end else if (tx_valid) begin
                shreg_d   = tx_data;
                last_d    = tx_last;
                bit_cnt_d = '0;
                emit      = 1'b1;
                emit_bit  = tx_data[0];
            end else begin
                err_d  = 1'b1;
                to_eop = 1'b1;
            end
        end

        if (to_eop) begin
            state_d   = EOP_SE0;
            bit_cnt_d = '0;
            ones_d    = '0;
            dp_d      = 1'b0;
            dn_d      = 1'b0;
        end

        // NRZI: a 1 holds the level and extends the run, a 0 (or stuff bit) toggles and clears it.
        if (emit) begin
            if (emit_bit) begin
                ones_d = ones + OW'(1);
            end else begin
                lvl_d  = ~lvl;
                ones_d = '0;
            end
            dp_d = lvl_d;
            dn_d = ~lvl_d;
        end
    end

endmodule

// File: tb/tb_usb_phy_tx.sv
// Directed bench for usb_phy_tx: line sequences, timing and handshake checks against hand-derived values.
// Latency: outputs sampled 1 ns after each rising edge; bits sampled mid-bit.
// Backpressure: the bench plays the SIE, supplying or withholding bytes on tx_ready.
module tb_usb_phy_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_err;
    logic       tx_oe;
    logic       dp_tx;
    logic       dn_tx;

    int n_checks = 0;
    int n_fails  = 0;

    byte line_obs[$];
    int  rdy_edge[$];
    int  oe_cnt, busy_cnt, err_n, err_edge;

    usb_phy_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_err   (tx_err),
        .tx_oe    (tx_oe),
        .dp_tx    (dp_tx),
        .dn_tx    (dn_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input string tag, input byte obs, input byte exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %c expected %c", tag, obs, exp);
        end
    endtask

    function automatic byte line_ch();
        case ({dp_tx, dn_tx})
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "S";
            default: return "X";
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_line(input string tag, input string exp);
        chk({tag, "_nbits"}, line_obs.size(), exp.len());
        for (int i = 0; i < exp.len() && i < line_obs.size(); i++)
            chk_ch($sformatf("%s_bit%0d", tag, i), line_obs[i], exp[i]);
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("idle_tx_ready", int'(tx_ready), 1);
    endtask

    // Sends up to three bytes; byte index 'starve' is withheld to force an underrun.
    // Edge 0 is the accepting edge; all recorded times are edges after it.
    task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input int starve);
        logic [7:0] bytes [3];
        int idx, c;
        logic got;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        line_obs.delete();
        rdy_edge.delete();
        oe_cnt = 0; busy_cnt = 0; err_n = 0; err_edge = -1;
        wait_ready();
        tx_data  = bytes[0];
        tx_last  = (n == 1);
        tx_valid = 1'b1;
        tick();
        idx = 1;
        if (idx < n && idx != starve) begin
            tx_valid = 1'b1; tx_data = bytes[idx]; tx_last = (idx == n - 1);
        end else begin
            tx_valid = 1'b0; tx_data = 8'h5A; tx_last = 1'b1;
        end
        c = 0;
        while (c < 400 && tx_oe === 1'b1) begin
            oe_cnt++;
            if (tx_busy === 1'b1) busy_cnt++;
            if (c % 4 == 2) line_obs.push_back(line_ch());
            if (tx_err === 1'b1) begin err_n++; err_edge = c; end
            if (tx_ready === 1'b1) rdy_edge.push_back(c + 1);
            got = tx_ready && tx_valid;
            tick();
            c++;
            if (got) begin
                idx++;
                if (idx < n && idx != starve) begin
                    tx_valid = 1'b1; tx_data = bytes[idx]; tx_last = (idx == n - 1);
                end else begin
                    tx_valid = 1'b0; tx_data = 8'h5A; tx_last = 1'b1;
                end
            end
        end
        chk("packet_end_oe", int'(tx_oe), 0);
        chk("packet_end_busy", int'(tx_busy), 0);
        tx_valid = 1'b0;
    endtask

    initial begin
        int first_low, rise, w;
        byte idle_line, k_line;
        string sync_s, ack_s;
        sync_s = "KJKJKJKK";
        ack_s  = {sync_s, "JJKJJKKK", "SSJ"};

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        #2;
        chk("reset_dp", int'(dp_tx), 1);
        chk("reset_dn", int'(dn_tx), 0);
        chk("reset_oe", int'(tx_oe), 0);
        chk("reset_ready", int'(tx_ready), 0);
        chk("reset_busy", int'(tx_busy), 0);
        chk("reset_err", int'(tx_err), 0);
        tick();
        rst = 1'b0;

        // ACK PID alone
        run_packet(8'hD2, 8'h00, 8'h00, 1, 99);
        chk_line("ack", ack_s);
        chk("ack_oe_clocks", oe_cnt, 76);
        chk("ack_busy_clocks", busy_cnt, 76);
        chk("ack_ready_pulses", rdy_edge.size(), 0);
        chk("ack_err", err_n, 0);

        // 0xFF: stuffed 0 after the fifth payload 1
        run_packet(8'hFF, 8'h00, 8'h00, 1, 99);
        chk_line("ff", {sync_s, "KKKKKJJJJ", "SSJ"});
        chk("ff_oe_clocks", oe_cnt, 80);
        chk("ff_err", err_n, 0);

        // three bytes, runs of 1s never reach the stuff limit
        run_packet(8'hC3, 8'h00, 8'h00, 3, 99);
        chk_line("three", {sync_s, "KKJKJKKK", "JKJKJKJK", "JKJKJKJK", "SSJ"});
        chk("three_oe_clocks", oe_cnt, 140);
        chk("three_busy_clocks", busy_cnt, 140);
        chk("three_ready_pulses", rdy_edge.size(), 2);
        if (rdy_edge.size() == 2) begin
            chk("three_ready_edge0", rdy_edge[0], 64);
            chk("three_ready_edge1", rdy_edge[1], 96);
        end
        chk("three_err", err_n, 0);

        // underrun on the second byte
        run_packet(8'hD2, 8'h11, 8'h00, 2, 1);
        chk_line("underrun", ack_s);
        chk("underrun_oe_clocks", oe_cnt, 76);
        chk("underrun_err_pulses", err_n, 1);
        chk("underrun_err_edge", err_edge, 64);
        chk("underrun_ready_pulses", rdy_edge.size(), 1);
        if (rdy_edge.size() == 1)
            chk("underrun_ready_edge", rdy_edge[0], 64);

        // reset between edges in the middle of the payload
        wait_ready();
        tx_data = 8'hD2; tx_last = 1'b1; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (40) tick();
        chk("midpkt_oe_before_rst", int'(tx_oe), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_dp", int'(dp_tx), 1);
        chk("midrst_dn", int'(dn_tx), 0);
        chk("midrst_oe", int'(tx_oe), 0);
        chk("midrst_busy", int'(tx_busy), 0);
        chk("midrst_ready", int'(tx_ready), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        run_packet(8'hD2, 8'h00, 8'h00, 1, 99);
        chk_line("after_rst", ack_s);
        chk("after_rst_oe_clocks", oe_cnt, 76);

        // back-to-back packets with tx_valid held high
        wait_ready();
        tx_data = 8'hD2; tx_last = 1'b1; tx_valid = 1'b1;
        tick();
        first_low = -1; rise = -1; idle_line = "?"; k_line = "?";
        for (int c = 0; c < 200 && rise < 0; c++) begin
            if (first_low < 0 && tx_oe === 1'b0) begin
                first_low = c;
                idle_line = line_ch();
            end else if (first_low >= 0 && tx_oe === 1'b1) begin
                rise   = c;
                k_line = line_ch();
                tx_valid = 1'b0;
            end
            if (rise < 0) tick();
        end
        chk("b2b_oe_fall_edge", first_low, 76);
        chk("b2b_oe_rise_edge", rise, 77);
        chk_ch("b2b_idle_line", idle_line, "J");
        chk_ch("b2b_first_sync", k_line, "K");
        w = 0;
        while (tx_oe === 1'b1 && w < 200) begin
            tick();
            w++;
        end
        chk("b2b_second_oe_clocks", w, 76);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/usb_phy_tx.md
Name: usb_phy_tx

Overview:
- Full-speed USB device transmit front end, running at the 48 MHz core clock (4 clocks per 12 Mb/s bit).
- Accepts packet bytes from the SIE over a valid/ready handshake.
- Emits SYNC, the bit-stuffed, NRZI-encoded payload, and EOP on registered dp/dn with an output enable.
- Counterpart of the device's receive path; sits between the SIE and the bidirectional pad buffers.

Parameters:
- CLK_PER_BIT, 4, core clocks per USB bit time (must be >= 2).
- STUFF_LEN, 6, consecutive 1s after which a 0 is stuffed.
- EOP_SE0_BITS, 2, bit times of SE0 in EOP.

Ports:
- clk  in  1  48 MHz core clock.
- rst  in  1  reset; asynchronous assert, active-high.
- tx_valid  in  1  SIE has a byte on tx_data.
- tx_data  in  8  packet byte, LSB sent first; PID is the first byte.
- tx_last  in  1  qualifies tx_data as final byte of packet.
- tx_ready  out  1  byte accepted this cycle when tx_valid && tx_ready.
- tx_busy  out  1  packet in progress (SYNC start through EOP J).
- tx_err  out  1  one-clock pulse on underrun.
- tx_oe  out  1  pad output enable.
- dp_tx  out  1  D+ drive value.
- dn_tx  out  1  D- drive value.

Behaviour:
- Reset values (async, immediate): state IDLE; dp_tx=1, dn_tx=0 (J); tx_oe=0; tx_ready=0; tx_busy=0; tx_err=0; ones counter=0; bit-phase counter=0.
- All outputs are registered except tx_ready, which decodes registered state only and has no combinational path from inputs.
- States: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- Bit timing: a phase counter runs 0..CLK_PER_BIT-1 outside IDLE. The line changes only on the edge where the counter wraps, or on IDLE exit.
- IDLE -> SYNC: at the edge where tx_valid=1 is sampled in IDLE.
  - That byte is accepted at the same edge (tx_ready=1 in IDLE) and held as the first payload byte.
  - At that edge tx_oe=1, tx_busy=1, and the first SYNC bit is driven.
- SYNC: 8 bits 0000_0001 (LSB first); the ones counter is 1 at the end of SYNC. Then -> DATA with the held byte.
- NRZI: data 0 toggles J/K; data 1 holds. Line level before SYNC is J, so SYNC reads K J K J K J K K.
- Stuffing counter:
  - Each transmitted 1 increments it.
  - A 0 or a stuff bit clears it.
  - When it reaches STUFF_LEN, the next bit time is STUFF (a 0 bit), then the interrupted sequence resumes.
  - Stuffing also applies after the final data bit, before EOP. The counter is not cleared across byte boundaries.
- Byte fetch: tx_ready=1 for exactly one clock, on the wrap edge ending bit 7 of the current byte, if that byte was not tx_last.
  - If a stuff bit is pending, tx_ready asserts on the wrap edge ending that stuff bit instead.
  - On transfer, the next byte's bit 0 starts with no gap.
- Underrun: tx_ready=1 but tx_valid=0 -> tx_err=1 for that clock; go to EOP_SE0 (stuff bit emitted first if pending). The packet is truncated.
- EOP:
  - EOP_SE0: dp=dn=0 for EOP_SE0_BITS bit times.
  - EOP_J: J for 1 bit time.
  - -> IDLE: tx_oe=0, tx_busy=0, dp=1, dn=0.
  - NRZI state reinitialises to J.
- IDLE minimum is 1 clock: tx_valid held high through EOP starts a new SYNC 1 clock after IDLE entry. Inter-packet gap is the SIE's job.
- tx_data and tx_last are sampled only on transfer; changes at other times are ignored.
- Packet duration: tx_oe high for CLK_PER_BIT*(8 + 8N + stuff_bits + EOP_SE0_BITS + 1) clocks.
- Reset mid-packet: outputs return to reset values immediately (no clock needed). The packet is abandoned with no EOP.

Test Plan:
1. ACK (0xD2, tx_last=1):
   - line K J K J K J K K | J J K J J K K K | SE0 SE0 J;
   - tx_oe high exactly 76 clocks; tx_ready pulses 0 times after initial accept; tx_err=0.
2. 0xFF single byte with tx_last:
   - stuff 0 after bit 4 (SYNC's 1 + 5 ones);
   - line after SYNC: K K K K K J J J J, then EOP;
   - tx_oe high 80 clocks.
3. Three bytes 0xC3, 0x00, 0x00 (last on third):
   - tx_ready pulses at 64 and 96 clocks after SYNC start;
   - no stuffing; tx_oe high 140 clocks; tx_busy falls with tx_oe.
4. Two-byte packet, tx_valid=0 when the second byte is requested:
   - tx_err 1-clock pulse at that edge; SE0 begins on the same edge;
   - tx_oe high 76 clocks.
5. rst=1 asserted mid-DATA between clock edges:
   - dp=1, dn=0, tx_oe=0, tx_busy=0 immediately;
   - after release, tx_valid produces a clean SYNC starting with K.
6. Back-to-back packets with tx_valid held high:
   - exactly 1 clock with tx_oe=0/J between EOP J end and the next SYNC's first K.
